// File: rtl/ahb_lite_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter: M0 (fetch) and M1 (data)
// share one slave-side master port.
//
// Ports:
//   HCLK, HRESET             clock, synchronous active-high reset
//   H*_M0 / H*_M1            master-side address/data phase inputs
//   HRDATA_Mx, HREADY_Mx     master-side read data and per-master ready
//   HADDR..HSIZE, HWDATA     slave-side address phase and write data
//   HREADY, HRDATA           slave-side ready and read data
//   DPH_OWNER                {data phase valid, owning master}
//
// A master that loses arbitration (or requests during a slave wait) has
// its address phase captured in a one-deep pending register and is held
// off through its HREADY until that request is issued.

module ahb_lite_master_arbiter #(
   parameter int ARB_MODE  = 0,
   parameter int HIGH_PRIO = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,

   input  logic [31:0] HADDR_M0,
   input  logic [1:0]  HTRANS_M0,
   input  logic        HWRITE_M0,
   input  logic [2:0]  HSIZE_M0,
   input  logic [31:0] HWDATA_M0,
   output logic [31:0] HRDATA_M0,
   output logic        HREADY_M0,

   input  logic [31:0] HADDR_M1,
   input  logic [1:0]  HTRANS_M1,
   input  logic        HWRITE_M1,
   input  logic [2:0]  HSIZE_M1,
   input  logic [31:0] HWDATA_M1,
   output logic [31:0] HRDATA_M1,
   output logic        HREADY_M1,

   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,

   output logic [1:0]  DPH_OWNER
);

   localparam logic LP_RR = (ARB_MODE != 0);
   localparam logic LP_HI = (HIGH_PRIO != 0);

   // pending address phase per master
   logic [1:0]  r_pend_v;
   logic [31:0] r_pend_addr  [2];
   logic [1:0]  r_pend_write;
   logic [2:0]  r_pend_size  [2];

   // data phase owner and round-robin history
   logic        r_dph_v;
   logic        r_dph_own;
   logic        r_last_gnt;

   // live master inputs gathered into arrays
   logic [31:0] w_addr_m  [2];
   logic [1:0]  w_trans_m [2];
   logic [1:0]  w_write_m;
   logic [2:0]  w_size_m  [2];

   // per-master ready, live/effective request and fields
   logic [1:0]  w_rdy;
   logic [1:0]  w_live;
   logic [1:0]  w_req;
   logic [31:0] w_eff_addr  [2];
   logic [1:0]  w_eff_write;
   logic [2:0]  w_eff_size  [2];

   // arbitration result
   logic        w_win;
   logic        w_gnt_v;

   assign w_addr_m[0]  = HADDR_M0;
   assign w_addr_m[1]  = HADDR_M1;
   assign w_trans_m[0] = HTRANS_M0;
   assign w_trans_m[1] = HTRANS_M1;
   assign w_write_m    = {HWRITE_M1, HWRITE_M0};
   assign w_size_m[0]  = HSIZE_M0;
   assign w_size_m[1]  = HSIZE_M1;

   // The data-phase owner follows the slave ready; a master with a
   // pending request is stalled; anyone else is free to start.
   always_comb begin
      w_rdy       = 2'b00;
      w_live      = 2'b00;
      w_req       = 2'b00;
      w_eff_write = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (r_dph_v && (r_dph_own == 1'(i))) begin
            w_rdy[i] = HREADY;
         end else begin
            w_rdy[i] = ~r_pend_v[i];
         end
         w_live[i] = w_trans_m[i][1] & w_rdy[i];
         w_req[i]  = r_pend_v[i] | w_live[i];
         if (r_pend_v[i]) begin
            w_eff_addr[i]  = r_pend_addr[i];
            w_eff_write[i] = r_pend_write[i];
            w_eff_size[i]  = r_pend_size[i];
         end else begin
            w_eff_addr[i]  = w_addr_m[i];
            w_eff_write[i] = w_write_m[i];
            w_eff_size[i]  = w_size_m[i];
         end
      end
   end

   // Winner select; only meaningful when w_gnt_v is set.
   always_comb begin
      w_win = 1'b0;
      if (w_req[0] && w_req[1]) begin
         w_win = LP_RR ? ~r_last_gnt : LP_HI;
      end else begin
         w_win = w_req[1];
      end
      // no address phase is ever offered during a slave wait or reset
      w_gnt_v = HREADY & ~HRESET & (|w_req);
   end

   // Slave-side address phase.
   always_comb begin
      HTRANS = 2'b00;
      HADDR  = 32'h0;
      HWRITE = 1'b0;
      HSIZE  = 3'b000;
      if (w_gnt_v) begin
         HTRANS = 2'b10;
         HADDR  = w_eff_addr[w_win];
         HWRITE = w_eff_write[w_win];
         HSIZE  = w_eff_size[w_win];
      end
   end

   // Data-phase steering and master-side status.
   always_comb begin
      HWDATA = 32'h0;
      if (!HRESET && r_dph_v) begin
         HWDATA = r_dph_own ? HWDATA_M1 : HWDATA_M0;
      end
      HRDATA_M0 = HRDATA;
      HRDATA_M1 = HRDATA;
      HREADY_M0 = HRESET | w_rdy[0];
      HREADY_M1 = HRESET | w_rdy[1];
      DPH_OWNER = 2'b00;
      if (!HRESET) begin
         DPH_OWNER = {r_dph_v, r_dph_v & r_dph_own};
      end
   end

   // Control state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_pend_v   <= 2'b00;
         r_dph_v    <= 1'b0;
         r_dph_own  <= 1'b0;
         r_last_gnt <= 1'b1;
      end else begin
         if (HREADY) begin
            r_dph_v <= w_gnt_v;
         end
         if (w_gnt_v) begin
            r_dph_own  <= w_win;
            r_last_gnt <= w_win;
         end
         for (int i = 0; i < 2; i++) begin
            if (w_gnt_v && (w_win == 1'(i))) begin
               r_pend_v[i] <= 1'b0;
            end else if (w_live[i]) begin
               r_pend_v[i] <= 1'b1;
            end
         end
      end
   end

   // Pending address fields; qualified by r_pend_v so no reset needed.
   always_ff @(posedge HCLK) begin
      for (int i = 0; i < 2; i++) begin
         if (w_live[i] && !(w_gnt_v && (w_win == 1'(i)))) begin
            r_pend_addr[i]  <= w_addr_m[i];
            r_pend_write[i] <= w_write_m[i];
            r_pend_size[i]  <= w_size_m[i];
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Bench for ahb_lite_master_arbiter: a fixed-priority and a round-robin
// instance share stimulus and are checked against a request-level model.
module tb_ahb_lite_master_arbiter;

   logic HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   logic        rst;
   logic [31:0] haddr_m  [2];
   logic [1:0]  htrans_m [2];
   logic        hwrite_m [2];
   logic [2:0]  hsize_m  [2];
   logic [31:0] hwdata_m [2];
   logic        s_hready;
   logic [31:0] s_hrdata;

   // index 0 = fixed priority (HIGH_PRIO=1), index 1 = round robin
   logic [31:0] o_rd0   [2];
   logic [31:0] o_rd1   [2];
   logic        o_rdy0  [2];
   logic        o_rdy1  [2];
   logic [31:0] o_haddr [2];
   logic [1:0]  o_htrans[2];
   logic        o_hwrite[2];
   logic [2:0]  o_hsize [2];
   logic [31:0] o_hwdata[2];
   logic [1:0]  o_dph   [2];

   ahb_lite_master_arbiter #(.ARB_MODE(0), .HIGH_PRIO(1)) u_fix (
      .HCLK(HCLK), .HRESET(rst),
      .HADDR_M0(haddr_m[0]), .HTRANS_M0(htrans_m[0]), .HWRITE_M0(hwrite_m[0]),
      .HSIZE_M0(hsize_m[0]), .HWDATA_M0(hwdata_m[0]),
      .HRDATA_M0(o_rd0[0]), .HREADY_M0(o_rdy0[0]),
      .HADDR_M1(haddr_m[1]), .HTRANS_M1(htrans_m[1]), .HWRITE_M1(hwrite_m[1]),
      .HSIZE_M1(hsize_m[1]), .HWDATA_M1(hwdata_m[1]),
      .HRDATA_M1(o_rd1[0]), .HREADY_M1(o_rdy1[0]),
      .HADDR(o_haddr[0]), .HTRANS(o_htrans[0]), .HWRITE(o_hwrite[0]),
      .HSIZE(o_hsize[0]), .HWDATA(o_hwdata[0]),
      .HREADY(s_hready), .HRDATA(s_hrdata), .DPH_OWNER(o_dph[0])
   );

   ahb_lite_master_arbiter #(.ARB_MODE(1), .HIGH_PRIO(1)) u_rr (
      .HCLK(HCLK), .HRESET(rst),
      .HADDR_M0(haddr_m[0]), .HTRANS_M0(htrans_m[0]), .HWRITE_M0(hwrite_m[0]),
      .HSIZE_M0(hsize_m[0]), .HWDATA_M0(hwdata_m[0]),
      .HRDATA_M0(o_rd0[1]), .HREADY_M0(o_rdy0[1]),
      .HADDR_M1(haddr_m[1]), .HTRANS_M1(htrans_m[1]), .HWRITE_M1(hwrite_m[1]),
      .HSIZE_M1(hsize_m[1]), .HWDATA_M1(hwdata_m[1]),
      .HRDATA_M1(o_rd1[1]), .HREADY_M1(o_rdy1[1]),
      .HADDR(o_haddr[1]), .HTRANS(o_htrans[1]), .HWRITE(o_hwrite[1]),
      .HSIZE(o_hsize[1]), .HWDATA(o_hwdata[1]),
      .HREADY(s_hready), .HRDATA(s_hrdata), .DPH_OWNER(o_dph[1])
   );

   int n_assert = 0;
   int n_fail   = 0;

   // model: a pending request per master, data-phase owner (-1 = none)
   bit          m_pv [2][2];
   logic [31:0] m_pa [2][2];
   logic        m_pw [2][2];
   logic [2:0]  m_ps [2][2];
   int          m_own [2];
   int          m_last[2];
   int          m_win [2];
   bit          m_live[2][2];

   logic        e_rdy   [2][2];
   logic [31:0] e_haddr [2];
   logic [1:0]  e_htrans[2];
   logic        e_hwrite[2];
   logic [2:0]  e_hsize [2];
   logic [31:0] e_hwdata[2];
   logic [1:0]  e_dph   [2];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_out(input int k);
      bit has [2];
      bit rdy;
      int w;
      for (int i = 0; i < 2; i++) begin
         rdy = (m_own[k] == i) ? s_hready : !m_pv[k][i];
         m_live[k][i] = htrans_m[i][1] && rdy;
         has[i] = m_pv[k][i] || m_live[k][i];
         e_rdy[k][i] = rst ? 1'b1 : rdy;
      end
      w = -1;
      if (!rst && s_hready) begin
         if (has[0] && has[1]) w = (k == 0) ? 1 : 1 - m_last[k];
         else if (has[0]) w = 0;
         else if (has[1]) w = 1;
      end
      m_win[k] = w;
      e_htrans[k] = 2'b00;
      e_haddr[k]  = 32'h0;
      e_hwrite[k] = 1'b0;
      e_hsize[k]  = 3'b000;
      if (w >= 0) begin
         e_htrans[k] = 2'b10;
         e_haddr[k]  = m_pv[k][w] ? m_pa[k][w] : haddr_m[w];
         e_hwrite[k] = m_pv[k][w] ? m_pw[k][w] : hwrite_m[w];
         e_hsize[k]  = m_pv[k][w] ? m_ps[k][w] : hsize_m[w];
      end
      e_hwdata[k] = 32'h0;
      e_dph[k]    = 2'b00;
      if (!rst && m_own[k] >= 0) begin
         e_hwdata[k] = hwdata_m[m_own[k]];
         e_dph[k]    = (m_own[k] == 1) ? 2'b11 : 2'b10;
      end
   endtask

   task automatic model_step(input int k);
      if (rst) begin
         for (int i = 0; i < 2; i++) m_pv[k][i] = 1'b0;
         m_own[k]  = -1;
         m_last[k] = 1;
      end else begin
         if (s_hready) m_own[k] = m_win[k];
         if (m_win[k] >= 0) m_last[k] = m_win[k];
         for (int i = 0; i < 2; i++) begin
            if (m_win[k] == i) begin
               m_pv[k][i] = 1'b0;
            end else if (m_live[k][i]) begin
               m_pv[k][i] = 1'b1;
               m_pa[k][i] = haddr_m[i];
               m_pw[k][i] = hwrite_m[i];
               m_ps[k][i] = hsize_m[i];
            end
         end
      end
   endtask

   task automatic eval();
      string pf;
      @(negedge HCLK);
      for (int k = 0; k < 2; k++) begin
         pf = (k == 0) ? "fix" : "rr";
         model_out(k);
         chk({pf, " HRDATA_M0"}, o_rd0[k], s_hrdata);
         chk({pf, " HRDATA_M1"}, o_rd1[k], s_hrdata);
         chk({pf, " HREADY_M0"}, 32'(o_rdy0[k]), 32'(e_rdy[k][0]));
         chk({pf, " HREADY_M1"}, 32'(o_rdy1[k]), 32'(e_rdy[k][1]));
         chk({pf, " HADDR"}, o_haddr[k], e_haddr[k]);
         chk({pf, " HTRANS"}, 32'(o_htrans[k]), 32'(e_htrans[k]));
         chk({pf, " HWRITE"}, 32'(o_hwrite[k]), 32'(e_hwrite[k]));
         chk({pf, " HSIZE"}, 32'(o_hsize[k]), 32'(e_hsize[k]));
         chk({pf, " HWDATA"}, o_hwdata[k], e_hwdata[k]);
         chk({pf, " DPH_OWNER"}, 32'(o_dph[k]), 32'(e_dph[k]));
      end
   endtask

   task automatic adv();
      @(posedge HCLK);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic idle_in();
      for (int i = 0; i < 2; i++) begin
         htrans_m[i] = 2'b00;
         haddr_m[i]  = 32'h0;
         hwrite_m[i] = 1'b0;
         hsize_m[i]  = 3'b010;
         hwdata_m[i] = 32'h0;
      end
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         eval();
         adv();
      end
   endtask

   task automatic pulse_reset();
      idle_in();
      s_hready = 1'b1;
      rst = 1'b1;
      run(1);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_own[k]  = -1;
         m_last[k] = 1;
         for (int i = 0; i < 2; i++) m_pv[k][i] = 1'b0;
      end
      idle_in();
      s_hrdata = 32'h0;
      s_hready = 1'b1;
      rst = 1'b1;

      // reset held two cycles with both masters requesting
      htrans_m[0] = 2'b10; haddr_m[0] = 32'h10;
      htrans_m[1] = 2'b10; haddr_m[1] = 32'h20;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin
            rst = 1'b0;
            s_hready = 1'b0;
         end
         eval();
         chk("rst HREADY_M0", 32'(o_rdy0[0]), 32'd1);
         chk("rst HREADY_M1", 32'(o_rdy1[0]), 32'd1);
         chk("rst HTRANS", 32'(o_htrans[0]), 32'd0);
         chk("rst DPH_OWNER", 32'(o_dph[0]), 32'd0);
         adv();
      end
      idle_in();
      s_hready = 1'b1;
      run(4);

      // single M0 read
      htrans_m[0] = 2'b10; haddr_m[0] = 32'h0000_0100;
      eval();
      chk("m0rd HADDR", o_haddr[0], 32'h100);
      chk("m0rd HTRANS", 32'(o_htrans[0]), 32'd2);
      adv();
      idle_in();
      s_hrdata = 32'hCAFE_F00D;
      eval();
      chk("m0rd DPH_OWNER", 32'(o_dph[0]), 32'd2);
      chk("m0rd HRDATA_M0", o_rd0[0], 32'hCAFE_F00D);
      chk("m0rd HREADY_M0", 32'(o_rdy0[0]), 32'd1);
      adv();
      run(1);

      // simultaneous requests, fixed priority favours M1
      htrans_m[0] = 2'b10; haddr_m[0] = 32'h0000_0200;
      htrans_m[1] = 2'b10; haddr_m[1] = 32'h2000_0004; hwrite_m[1] = 1'b1;
      eval();
      chk("sim HADDR M1", o_haddr[0], 32'h2000_0004);
      chk("sim HWRITE M1", 32'(o_hwrite[0]), 32'd1);
      adv();
      idle_in();
      hwdata_m[1] = 32'h1234_5678;
      eval();
      chk("sim HREADY_M0 stall", 32'(o_rdy0[0]), 32'd0);
      chk("sim HADDR M0", o_haddr[0], 32'h200);
      chk("sim HTRANS M0", 32'(o_htrans[0]), 32'd2);
      chk("sim HWDATA M1", o_hwdata[0], 32'h1234_5678);
      chk("sim DPH_OWNER", 32'(o_dph[0]), 32'd3);
      adv();
      idle_in();
      eval();
      chk("sim DPH_OWNER M0", 32'(o_dph[0]), 32'd2);
      adv();
      run(2);

      // round robin with both masters requesting continuously
      pulse_reset();
      htrans_m[0] = 2'b10; haddr_m[0] = 32'h1000;
      htrans_m[1] = 2'b10; haddr_m[1] = 32'h2000;
      for (int c = 0; c < 6; c++) begin
         eval();
         chk("rr grant", o_haddr[1], (c % 2 == 1) ? 32'h2000 : 32'h1000);
         chk("rr HTRANS", 32'(o_htrans[1]), 32'd2);
         adv();
      end
      idle_in();
      run(3);

      // slave wait while M0 is pending behind M1's data phase
      pulse_reset();
      htrans_m[0] = 2'b10; haddr_m[0] = 32'h300;
      htrans_m[1] = 2'b10; haddr_m[1] = 32'h40; hwrite_m[1] = 1'b1;
      eval();
      chk("wait HADDR M1", o_haddr[0], 32'h40);
      adv();
      htrans_m[1] = 2'b00;
      s_hready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         eval();
         chk("wait HTRANS", 32'(o_htrans[0]), 32'd0);
         chk("wait HREADY_M0", 32'(o_rdy0[0]), 32'd0);
         chk("wait HREADY_M1", 32'(o_rdy1[0]), 32'd0);
         chk("wait DPH_OWNER", 32'(o_dph[0]), 32'd3);
         adv();
      end
      s_hready = 1'b1;
      htrans_m[0] = 2'b00;
      eval();
      chk("wait issue HADDR", o_haddr[0], 32'h300);
      chk("wait issue HTRANS", 32'(o_htrans[0]), 32'd2);
      chk("wait HREADY_M1 done", 32'(o_rdy1[0]), 32'd1);
      adv();
      idle_in();
      run(2);

      // reset while M0 pending and M1 owns the data phase
      htrans_m[0] = 2'b10; haddr_m[0] = 32'h500;
      htrans_m[1] = 2'b10; haddr_m[1] = 32'h600;
      eval();
      chk("mrst HADDR M1", o_haddr[0], 32'h600);
      adv();
      idle_in();
      s_hready = 1'b0;
      eval();
      chk("mrst pre HREADY_M0", 32'(o_rdy0[0]), 32'd0);
      chk("mrst pre DPH_OWNER", 32'(o_dph[0]), 32'd3);
      adv();
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      s_hready = 1'b1;
      eval();
      chk("mrst DPH_OWNER", 32'(o_dph[0]), 32'd0);
      chk("mrst HREADY_M0", 32'(o_rdy0[0]), 32'd1);
      chk("mrst HREADY_M1", 32'(o_rdy1[0]), 32'd1);
      chk("mrst HTRANS", 32'(o_htrans[0]), 32'd0);
      adv();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < 2; i++) begin
            htrans_m[i] = 2'($urandom_range(0, 3));
            haddr_m[i]  = $urandom;
            hwrite_m[i] = 1'($urandom_range(0, 1));
            hsize_m[i]  = 3'($urandom_range(0, 2));
            hwdata_m[i] = $urandom;
         end
         s_hready = ($urandom_range(0, 3) != 0);
         s_hrdata = $urandom;
         eval();
         adv();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
